// File: rtl/adc_processing_pkg.sv
// Shared types and threshold indexing for the ADC fault comparator bank.
// Threshold vector layout is index c*4+k (c = comparator, k = level).
package adc_processing_pkg;

  typedef enum logic {
    ARMED   = 1'b0,
    TRIPPED = 1'b1
  } comp_state_t;

  localparam int FAST = 0;
  localparam int SLOW = 1;

  localparam int LOW_TRIP     = 0;
  localparam int LOW_RELEASE  = 1;
  localparam int HIGH_RELEASE = 2;
  localparam int HIGH_TRIP    = 3;

  localparam int NUM_COMPARATORS = 2;
  localparam int NUM_LEVELS      = 4;
  localparam int NUM_THRESHOLDS  = NUM_COMPARATORS * NUM_LEVELS;

  function automatic int thr_index(input int comp, input int level);
    return comp * NUM_LEVELS + level;
  endfunction

endpackage

// File: rtl/adc_hysteresis_comparator.sv
// One window comparator: independent high-side and low-side ARMED/TRIPPED FSMs
// with hysteretic or latching release and a level clear that beats any trip.
module adc_hysteresis_comparator
  import adc_processing_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              sample_valid,
  input  logic signed [DATA_PATH_WIDTH-1:0] sample,
  input  logic signed [DATA_PATH_WIDTH-1:0] low_trip,
  input  logic signed [DATA_PATH_WIDTH-1:0] low_release,
  input  logic signed [DATA_PATH_WIDTH-1:0] high_release,
  input  logic signed [DATA_PATH_WIDTH-1:0] high_trip,
  input  logic                              latch_mode,
  input  logic                              clear_latch,
  output comp_state_t                       state_high,
  output comp_state_t                       state_low
);

  comp_state_t high_next;
  comp_state_t low_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_high <= ARMED;
      state_low  <= ARMED;
    end else begin
      state_high <= high_next;
      state_low  <= low_next;
    end
  end

  // Clear wins over everything; otherwise only valid samples move the FSMs.
  // Release thresholds are used as given even if they sit beyond the trip level.
  always_comb begin
    high_next = state_high;
    low_next  = state_low;
    if (clear_latch) begin
      high_next = ARMED;
      low_next  = ARMED;
    end else if (sample_valid) begin
      case (state_high)
        ARMED:   if (sample > high_trip) high_next = TRIPPED;
        TRIPPED: if (!latch_mode && (sample < high_release)) high_next = ARMED;
        default: high_next = ARMED;
      endcase
      case (state_low)
        ARMED:   if (sample < low_trip) low_next = TRIPPED;
        TRIPPED: if (!latch_mode && (sample > low_release)) low_next = ARMED;
        default: low_next = ARMED;
      endcase
    end
  end

endmodule

// File: rtl/adc_fault_comparators.sv
// Fast and slow window comparators on a calibrated ADC stream, with a
// registered sample pass-through aligned to the trip outputs.
module adc_fault_comparators
  import adc_processing_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              data_in_valid,
  input  logic signed [DATA_PATH_WIDTH-1:0] data_in_data,
  input  logic signed [DATA_PATH_WIDTH-1:0] comparator_thresholds [NUM_THRESHOLDS],
  input  logic [NUM_COMPARATORS-1:0]        latch_mode,
  input  logic [NUM_COMPARATORS-1:0]        clear_latch,
  output logic                              data_out_valid,
  output logic signed [DATA_PATH_WIDTH-1:0] data_out_data,
  output logic [NUM_COMPARATORS-1:0]        trip_high,
  output logic [NUM_COMPARATORS-1:0]        trip_low
);

  comp_state_t state_high [NUM_COMPARATORS];
  comp_state_t state_low  [NUM_COMPARATORS];

  for (genvar c = 0; c < NUM_COMPARATORS; c++) begin : g_comp
    adc_hysteresis_comparator #(
      .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
    ) u_comp (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (data_in_valid),
      .sample       (data_in_data),
      .low_trip     (comparator_thresholds[thr_index(c, LOW_TRIP)]),
      .low_release  (comparator_thresholds[thr_index(c, LOW_RELEASE)]),
      .high_release (comparator_thresholds[thr_index(c, HIGH_RELEASE)]),
      .high_trip    (comparator_thresholds[thr_index(c, HIGH_TRIP)]),
      .latch_mode   (latch_mode[c]),
      .clear_latch  (clear_latch[c]),
      .state_high   (state_high[c]),
      .state_low    (state_low[c])
    );

    // State registers are the trip registers, so trips share the data latency.
    assign trip_high[c] = (state_high[c] == TRIPPED);
    assign trip_low[c]  = (state_low[c] == TRIPPED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_valid <= 1'b0;
      data_out_data  <= '0;
    end else begin
      data_out_valid <= data_in_valid;
      if (data_in_valid) data_out_data <= data_in_data;
    end
  end

endmodule
